eco32_timer_cfg_seq: RTL and testbench
======================================

# eco32_timer_cfg_seq

Configuration sequencer for `eco32_timer_box`: holds a host-loaded staging table of slot entries and, on a commit request, drives the timer box's uplink event port to reprogram it atomically. The commit sequence is: disable, write every slot, set the valid slot count, set the clock divider, and optionally re-enable. It sits between the host-side register/event logic and a single timer box, and is the only master of that box's `ul_eve_*` port.

## Interface
- `MAX_SLOTS`, default 16: staging table depth; power of 2, 1..256.
- `SLOT_AW`, default 4: log2(`MAX_SLOTS`); table address width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tbl_wr_stb` in 1: staging table write strobe.
- `tbl_wr_addr` in `SLOT_AW`: table entry index.
- `tbl_wr_data` in 28: entry, {ena[27], cv[26:8], id[7:0]}.
- `cmt_stb` in 1: commit request.
- `cmt_slot_cnt` in 9: number of slots to program, 0..`MAX_SLOTS`.
- `cmt_clk_div` in 32: divider value.
- `cmt_start` in 1: 1 = enable the timer after the commit.
- `stop_stb` in 1: disable-only request.
- `cmt_ack` out 1: 1-cycle pulse when a commit or stop is accepted.
- `busy` out 1: sequence in progress.
- `done` out 1: 1-cycle pulse when a sequence completes.
- `err` out 1: 1-cycle pulse when a commit is rejected.
- `ul_eve_stb` out 1: command strobe to the timer box.
- `ul_eve_cmd` out 8: command code.
- `ul_eve_ptr` out 36: command payload.
- `ul_eve_ack` in 1: command accepted by the timer box.

## Operation
- **Staging table**
  - `MAX_SLOTS` x 28 synchronous RAM with 1-cycle read latency.
  - A write occurs on `tbl_wr_stb` only while `busy`=0. Writes while `busy`=1 are dropped.
- **Command codes and payloads**
  - SET_ENA 0x30: ptr = {35'd0, en}.
  - SLOT_CFG 0x31: ptr = {ena, cv[18:0], slot[7:0], id[7:0]} at bits 35, 34:16, 15:8, 7:0. `slot` is the table index, zero-extended to 8 bits.
  - VALID_SLOT_CNT 0x32: ptr = {27'd0, cnt[8:0]}.
  - CLK_DIV 0x33: ptr = {4'd0, div[31:0]}.
- **Latching at accept:** `cmt_slot_cnt`, `cmt_clk_div` and `cmt_start` are latched when a commit is accepted. Later input changes have no effect on the running sequence.
- **FSM states:** IDLE, DIS, RD, SLOT, CNT, DIV, ENA, FIN.
- **IDLE, accepting a commit:** on `cmt_stb`
  - If `cmt_slot_cnt` > `MAX_SLOTS`: pulse `err`, no `cmt_ack`, stay in IDLE.
  - Otherwise: pulse `cmt_ack`, set `busy`, go to DIS.
- **IDLE, stop request:** on `stop_stb` with no `cmt_stb`: pulse `cmt_ack`, set `busy`, go to DIS with the stop-only flag set.
- **Commit and stop together:** the commit wins and the stop is dropped, because the commit disables the timer anyway.
- **DIS:** issue SET_ENA(0). On ack:
  - stop-only → FIN;
  - cnt = 0 → CNT;
  - otherwise → RD with index = 0.
- **RD:** `ul_eve_stb`=0; read table[index]. Always → SLOT.
- **SLOT:** issue SLOT_CFG with the RAM output and `slot` = index. On ack:
  - index = cnt-1 → CNT;
  - otherwise index+1 → RD.
  - The index counter is `SLOT_AW`+1 bits wide, so cnt = `MAX_SLOTS` does not wrap.
- **CNT:** issue VALID_SLOT_CNT(cnt). On ack → DIV.
- **DIV:** issue CLK_DIV(div). On ack → ENA if `cmt_start`=1, else FIN.
- **ENA:** issue SET_ENA(1). On ack → FIN.
- **FIN:** pulse `done`, clear `busy`, → IDLE.
- **Requests while busy:** `cmt_stb` and `stop_stb` are ignored when `busy`=1 (no ack, no err).

## Timing
- **Reset values:** all outputs 0: `ul_eve_stb`, `ul_eve_cmd`, `ul_eve_ptr`, `cmt_ack`, `busy`, `done`, `err`. The FSM is in IDLE and the staging table contents are undefined.
- **Registered outputs:** all outputs are registered. `ul_eve_stb`/`cmd`/`ptr` rise in the cycle after the state is entered.
- **Command handshake:** a command completes in the cycle where `ul_eve_stb`=1 and `ul_eve_ack`=1. Until then `stb`, `cmd` and `ptr` are held stable.
  - `ul_eve_stb` is 0 in the cycle after an ack, except that the next command may be presented in that cycle when no RD state lies between the two commands.
- **Wait states:** a slow ack (held low for k cycles) stretches only the current command; there is no timeout.
- **Latency with same-cycle ack** (`eco32_timer_box` behaviour), commit accepted in cycle T:
  - `cmt_ack` and `busy` are high from T+1.
  - DIS command in T+1.
  - Each slot takes 2 cycles (RD + SLOT).
  - `done` in T+2N+5 with `cmt_start`=1, or T+2N+4 with `cmt_start`=0.
- **Stop latency:** stop accepted in T → SET_ENA(0) in T+1, `done` in T+2.
- **`busy` timing:** falls in the same cycle `done` pulses.
- **Reset mid-sequence:** the FSM returns to IDLE immediately and `ul_eve_stb` drops asynchronously. The timer box is expected to share `rst`.

## Test plan
- **Basic commit:** load 3 entries (ena=1, cv=5/7/9, id=0x11/0x22/0x33), commit cnt=3, div=100, start=1. Required command stream:
  - 0x30/0;
  - 0x31 with ptr {1,5,0,0x11}, {1,7,1,0x22}, {1,9,2,0x33};
  - 0x32/3;
  - 0x33/100;
  - 0x30/1;
  - `done` at T+11.
- **Zero slots, no start:** commit cnt=0, start=0. Required: 0x30/0, 0x32/0, 0x33/div only; no SET_ENA(1); `done` at T+4.
- **Overflow and full table:** commit cnt=`MAX_SLOTS`+1 → `err` pulse, no `cmt_ack`, no `ul_eve_stb`. Then commit cnt=`MAX_SLOTS` → exactly 16 SLOT_CFG commands, slots 0..15.
- **Back-pressure:** ack delayed 3 cycles on every command. Required: `cmd`/`ptr` stable while stb is high, each command issued exactly once, correct order.
- **Collisions while busy:** `cmt_stb` and `stop_stb` in the same IDLE cycle → commit sequence only. During busy, a table write to entry 0 and a second `cmt_stb` are both ignored; entry 0 still reads its old value on the next commit.
- **Reset mid-sequence:** assert `rst` during the SLOT state → all outputs 0 next edge. A subsequent commit then runs the full sequence from DIS.

Source files
------------

// File: rtl/eco32_timer_cfg_seq.sv
// Configuration sequencer for eco32_timer_box: stages slot entries and replays them
// over the uplink event port as disable / slots / count / divider / optional enable.
module eco32_timer_cfg_seq #(
  parameter int MAX_SLOTS = 16,
  parameter int SLOT_AW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_wr_stb,
  input  logic [SLOT_AW-1:0] tbl_wr_addr,
  input  logic [27:0]        tbl_wr_data,
  input  logic               cmt_stb,
  input  logic [8:0]         cmt_slot_cnt,
  input  logic [31:0]        cmt_clk_div,
  input  logic               cmt_start,
  input  logic               stop_stb,
  output logic               cmt_ack,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               ul_eve_stb,
  output logic [7:0]         ul_eve_cmd,
  output logic [35:0]        ul_eve_ptr,
  input  logic               ul_eve_ack
);

  localparam logic [7:0] CMD_SET_ENA   = 8'h30;
  localparam logic [7:0] CMD_SLOT_CFG  = 8'h31;
  localparam logic [7:0] CMD_VALID_CNT = 8'h32;
  localparam logic [7:0] CMD_CLK_DIV   = 8'h33;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DIS = 3'd1, S_RD = 3'd2, S_SLOT = 3'd3,
    S_CNT  = 3'd4, S_DIV = 3'd5, S_ENA = 3'd6, S_FIN = 3'd7
  } state_t;

  state_t             state_r, state_s;
  logic [SLOT_AW:0]   idx_r, idx_s;
  logic [27:0]        tbl_mem [MAX_SLOTS];
  logic [27:0]        ram_q_r;
  logic [8:0]         cnt_r;
  logic [31:0]        div_r;
  logic               start_r, stop_only_r;
  logic               cmd_done_s, cnt_ovf_s, acc_cmt_s, acc_stop_s, last_slot_s;
  logic               stb_s, ack_s, busy_s, done_s, err_s;
  logic [7:0]         cmd_s;
  logic [35:0]        ptr_s;

  assign cmd_done_s  = ul_eve_stb && ul_eve_ack;
  assign cnt_ovf_s   = cmt_slot_cnt > 9'(MAX_SLOTS);
  assign acc_cmt_s   = (state_r == S_IDLE) && cmt_stb && !cnt_ovf_s;
  assign acc_stop_s  = (state_r == S_IDLE) && !cmt_stb && stop_stb;
  assign last_slot_s = (9'(idx_r) + 9'd1) == cnt_r;

  // Staging table write port; the table is frozen while a sequence runs.
  always_ff @(posedge clk) begin
    if (tbl_wr_stb && !busy) tbl_mem[tbl_wr_addr] <= tbl_wr_data;
  end

  // Read addressed by the next index so the entry is valid throughout RD and SLOT.
  always_ff @(posedge clk) begin
    ram_q_r <= tbl_mem[idx_s[SLOT_AW-1:0]];
  end

  // State, index and accepted-request parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= {(SLOT_AW+1){1'b0}};
      cnt_r       <= 9'd0;
      div_r       <= 32'd0;
      start_r     <= 1'b0;
      stop_only_r <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (acc_cmt_s) begin
        cnt_r       <= cmt_slot_cnt;
        div_r       <= cmt_clk_div;
        start_r     <= cmt_start;
        stop_only_r <= 1'b0;
      end else if (acc_stop_s) begin
        stop_only_r <= 1'b1;
      end
    end
  end

  // Next-state and index sequencing; each command state waits for its handshake.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (acc_cmt_s || acc_stop_s) state_s = S_DIS;
        else                         state_s = S_IDLE;
      end
      S_DIS: begin
        if (!cmd_done_s)          state_s = S_DIS;
        else if (stop_only_r)     state_s = S_FIN;
        else if (cnt_r == 9'd0)   state_s = S_CNT;
        else begin
          state_s = S_RD;
          idx_s   = {(SLOT_AW+1){1'b0}};
        end
      end
      S_RD: state_s = S_SLOT;
      S_SLOT: begin
        if (!cmd_done_s)      state_s = S_SLOT;
        else if (last_slot_s) state_s = S_CNT;
        else begin
          state_s = S_RD;
          idx_s   = idx_r + {{SLOT_AW{1'b0}}, 1'b1};
        end
      end
      S_CNT: begin
        if (cmd_done_s) state_s = S_DIV;
        else            state_s = S_CNT;
      end
      S_DIV: begin
        if (!cmd_done_s) state_s = S_DIV;
        else if (start_r) state_s = S_ENA;
        else              state_s = S_FIN;
      end
      S_ENA: begin
        if (cmd_done_s) state_s = S_FIN;
        else            state_s = S_ENA;
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they appear as that state begins.
  always_comb begin
    stb_s  = 1'b0;
    cmd_s  = 8'h00;
    ptr_s  = 36'd0;
    case (state_s)
      S_DIS: begin
        stb_s = 1'b1;
        cmd_s = CMD_SET_ENA;
      end
      S_SLOT: begin
        stb_s = 1'b1;
        cmd_s = CMD_SLOT_CFG;
        ptr_s = {ram_q_r[27], ram_q_r[26:8], 8'(idx_s), ram_q_r[7:0]};
      end
      S_CNT: begin
        stb_s = 1'b1;
        cmd_s = CMD_VALID_CNT;
        ptr_s = {27'd0, cnt_r};
      end
      S_DIV: begin
        stb_s = 1'b1;
        cmd_s = CMD_CLK_DIV;
        ptr_s = {4'd0, div_r};
      end
      S_ENA: begin
        stb_s = 1'b1;
        cmd_s = CMD_SET_ENA;
        ptr_s = 36'd1;
      end
      default: begin
        stb_s = 1'b0;
        cmd_s = 8'h00;
        ptr_s = 36'd0;
      end
    endcase
    ack_s  = acc_cmt_s || acc_stop_s;
    err_s  = (state_r == S_IDLE) && cmt_stb && cnt_ovf_s;
    done_s = (state_s == S_FIN);
    busy_s = (state_s != S_IDLE) && (state_s != S_FIN);
  end

  // Output registers; reset clears the uplink strobe without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ul_eve_stb <= 1'b0;
      ul_eve_cmd <= 8'h00;
      ul_eve_ptr <= 36'd0;
      cmt_ack    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ul_eve_stb <= stb_s;
      ul_eve_cmd <= cmd_s;
      ul_eve_ptr <= ptr_s;
      cmt_ack    <= ack_s;
      busy       <= busy_s;
      done       <= done_s;
      err        <= err_s;
    end
  end

endmodule

// File: tb/tb_eco32_timer_cfg_seq.sv
// Directed bench for eco32_timer_cfg_seq: a handshake monitor logs every accepted
// uplink command, and each step compares the log and timing with hand-written values.
module tb_eco32_timer_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_wr_stb;
  logic [3:0]  tbl_wr_addr;
  logic [27:0] tbl_wr_data;
  logic        cmt_stb;
  logic [8:0]  cmt_slot_cnt;
  logic [31:0] cmt_clk_div;
  logic        cmt_start;
  logic        stop_stb;
  logic        cmt_ack, busy, done, err;
  logic        ul_eve_stb;
  logic [7:0]  ul_eve_cmd;
  logic [35:0] ul_eve_ptr;
  logic        ul_eve_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic [7:0]  log_cmd[$];
  logic [35:0] log_ptr[$];
  logic [7:0]  exp_cmd[$];
  logic [35:0] exp_ptr[$];
  int   stb_cnt, ack_cnt, err_cnt, done_cnt, done_cyc;
  bit   done_seen, done_busy, prev_hold;
  logic [7:0]  prev_cmd;
  logic [35:0] prev_ptr;

  eco32_timer_cfg_seq #(.MAX_SLOTS(16), .SLOT_AW(4)) dut (
    .clk(clk), .rst(rst),
    .tbl_wr_stb(tbl_wr_stb), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .cmt_stb(cmt_stb), .cmt_slot_cnt(cmt_slot_cnt), .cmt_clk_div(cmt_clk_div),
    .cmt_start(cmt_start), .stop_stb(stop_stb),
    .cmt_ack(cmt_ack), .busy(busy), .done(done), .err(err),
    .ul_eve_stb(ul_eve_stb), .ul_eve_cmd(ul_eve_cmd), .ul_eve_ptr(ul_eve_ptr),
    .ul_eve_ack(ul_eve_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer-box model: acknowledges after ack_delay wait cycles.
  assign ul_eve_ack = ul_eve_stb && (wait_cnt >= ack_delay);
  always @(posedge clk) begin
    if (ul_eve_stb && !ul_eve_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_stb", {63'd0, ul_eve_stb}, 64'd1);
        chk("hold_cmd", {56'd0, ul_eve_cmd}, {56'd0, prev_cmd});
        chk("hold_ptr", {28'd0, ul_eve_ptr}, {28'd0, prev_ptr});
      end
      prev_hold = ul_eve_stb && !ul_eve_ack;
      prev_cmd  = ul_eve_cmd;
      prev_ptr  = ul_eve_ptr;
      if (ul_eve_stb) stb_cnt++;
      if (ul_eve_stb && ul_eve_ack) begin
        log_cmd.push_back(ul_eve_cmd);
        log_ptr.push_back(ul_eve_ptr);
      end
      if (done) begin
        if (!done_seen) begin
          done_cyc  = cyc;
          done_busy = busy;
        end
        done_seen = 1'b1;
        done_cnt++;
      end
      if (cmt_ack) ack_cnt++;
      if (err) err_cnt++;
    end else begin
      prev_hold = 1'b0;
    end
  end

  function automatic logic [27:0] full_entry(input int i);
    logic [7:0] s;
    s = 8'(i);
    return {s[0], 19'(i + 1), 8'h40 + s};
  endfunction

  function automatic logic [35:0] full_ptr(input int i);
    logic [7:0] s;
    s = 8'(i);
    return {s[0], 19'(i + 1), s, 8'h40 + s};
  endfunction

  task automatic clear_log();
    log_cmd.delete(); log_ptr.delete(); exp_cmd.delete(); exp_ptr.delete();
    stb_cnt = 0; ack_cnt = 0; err_cnt = 0; done_cnt = 0; done_cyc = 0;
    done_seen = 1'b0; done_busy = 1'b0;
  endtask

  task automatic expect_cmd(input logic [7:0] c, input logic [35:0] p);
    exp_cmd.push_back(c);
    exp_ptr.push_back(p);
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk($sformatf("%s_len", tag), 64'(log_cmd.size()), 64'(exp_cmd.size()));
    n = (log_cmd.size() < exp_cmd.size()) ? log_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), {56'd0, log_cmd[i]}, {56'd0, exp_cmd[i]});
      chk($sformatf("%s_ptr%0d", tag, i), {28'd0, log_ptr[i]}, {28'd0, exp_ptr[i]});
    end
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [27:0] d);
    @(negedge clk);
    tbl_wr_stb = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
    @(negedge clk);
    tbl_wr_stb = 1'b0;
  endtask

  // Presents one request cycle (cycle T = t0) and returns at the falling edge of T+1.
  task automatic request(input bit c, input bit s, input logic [8:0] n,
                         input logic [31:0] dv, input bit st);
    clear_log();
    @(negedge clk);
    cmt_stb = c; stop_stb = s; cmt_slot_cnt = n; cmt_clk_div = dv; cmt_start = st;
    t0 = cyc;
    @(negedge clk);
    cmt_stb = 1'b0; stop_stb = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!done_seen && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk($sformatf("%s_done_seen", tag), {63'd0, done_seen}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; tbl_wr_stb = 1'b0; tbl_wr_addr = 4'd0; tbl_wr_data = 28'd0;
    cmt_stb = 1'b0; cmt_slot_cnt = 9'd0; cmt_clk_div = 32'd0; cmt_start = 1'b0;
    stop_stb = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_stb",  {63'd0, ul_eve_stb}, 64'd0);
    chk("rst_cmd",  {56'd0, ul_eve_cmd}, 64'd0);
    chk("rst_ptr",  {28'd0, ul_eve_ptr}, 64'd0);
    chk("rst_ack",  {63'd0, cmt_ack}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err",  {63'd0, err}, 64'd0);
    rst = 1'b0;

    // Basic commit: three slots, start=1.
    tbl_write(4'd0, 28'h8000511);
    tbl_write(4'd1, 28'h8000722);
    tbl_write(4'd2, 28'h8000933);
    request(1'b1, 1'b0, 9'd3, 32'd100, 1'b1);
    chk("basic_ack_t1",  {63'd0, cmt_ack}, 64'd1);
    chk("basic_busy_t1", {63'd0, busy}, 64'd1);
    chk("basic_stb_t1",  {63'd0, ul_eve_stb}, 64'd1);
    wait_done("basic", 100);
    chk("basic_done_t", 64'(done_cyc - t0), 64'd11);
    chk("basic_busy_at_done", {63'd0, done_busy}, 64'd0);
    expect_cmd(8'h30, 36'h000000000);
    expect_cmd(8'h31, 36'h800050011);
    expect_cmd(8'h31, 36'h800070122);
    expect_cmd(8'h31, 36'h800090233);
    expect_cmd(8'h32, 36'h000000003);
    expect_cmd(8'h33, 36'h000000064);
    expect_cmd(8'h30, 36'h000000001);
    check_stream("basic");

    // Zero slots, no start.
    request(1'b1, 1'b0, 9'd0, 32'h1234, 1'b0);
    wait_done("zero", 50);
    chk("zero_done_t", 64'(done_cyc - t0), 64'd4);
    expect_cmd(8'h30, 36'h000000000);
    expect_cmd(8'h32, 36'h000000000);
    expect_cmd(8'h33, 36'h000001234);
    check_stream("zero");

    // Stop-only request.
    request(1'b0, 1'b1, 9'd5, 32'd77, 1'b1);
    wait_done("stop", 50);
    chk("stop_done_t", 64'(done_cyc - t0), 64'd2);
    chk("stop_ack_cnt", 64'(ack_cnt), 64'd1);
    expect_cmd(8'h30, 36'h000000000);
    check_stream("stop");

    // Overflowing count is rejected.
    request(1'b1, 1'b0, 9'd17, 32'd5, 1'b1);
    chk("ovf_err_t1",  {63'd0, err}, 64'd1);
    chk("ovf_ack_t1",  {63'd0, cmt_ack}, 64'd0);
    chk("ovf_busy_t1", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    chk("ovf_stb_cnt", 64'(stb_cnt), 64'd0);
    chk("ovf_ack_cnt", 64'(ack_cnt), 64'd0);
    chk("ovf_err_cnt", 64'(err_cnt), 64'd1);

    // Full table of 16 slots.
    for (int i = 0; i < 16; i++) tbl_write(4'(i), full_entry(i));
    request(1'b1, 1'b0, 9'd16, 32'd7, 1'b1);
    wait_done("full", 200);
    chk("full_done_t", 64'(done_cyc - t0), 64'd37);
    expect_cmd(8'h30, 36'h000000000);
    for (int i = 0; i < 16; i++) expect_cmd(8'h31, full_ptr(i));
    expect_cmd(8'h32, 36'h000000010);
    expect_cmd(8'h33, 36'h000000007);
    expect_cmd(8'h30, 36'h000000001);
    check_stream("full");

    // Back-pressure: every ack delayed three cycles.
    ack_delay = 3;
    request(1'b1, 1'b0, 9'd2, 32'd9, 1'b1);
    wait_done("bp", 200);
    expect_cmd(8'h30, 36'h000000000);
    expect_cmd(8'h31, 36'h000010040);
    expect_cmd(8'h31, 36'h800020141);
    expect_cmd(8'h32, 36'h000000002);
    expect_cmd(8'h33, 36'h000000009);
    expect_cmd(8'h30, 36'h000000001);
    check_stream("bp");
    chk("bp_stb_cycles", 64'(stb_cnt), 64'd24);
    chk("bp_done_cnt", 64'(done_cnt), 64'd1);
    ack_delay = 0;

    // Commit + stop together, then writes and commits while busy are dropped.
    request(1'b1, 1'b1, 9'd1, 32'd5, 1'b0);
    tbl_wr_stb = 1'b1; tbl_wr_addr = 4'd0; tbl_wr_data = 28'hFFFFFFF;
    cmt_stb = 1'b1; cmt_slot_cnt = 9'd0; cmt_clk_div = 32'd99; cmt_start = 1'b1;
    @(negedge clk);
    tbl_wr_stb = 1'b0; cmt_stb = 1'b0;
    wait_done("coll", 50);
    chk("coll_done_t", 64'(done_cyc - t0), 64'd6);
    chk("coll_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("coll_err_cnt", 64'(err_cnt), 64'd0);
    expect_cmd(8'h30, 36'h000000000);
    expect_cmd(8'h31, 36'h000010040);
    expect_cmd(8'h32, 36'h000000001);
    expect_cmd(8'h33, 36'h000000005);
    check_stream("coll");
    request(1'b1, 1'b0, 9'd1, 32'd6, 1'b0);
    wait_done("keep", 50);
    expect_cmd(8'h30, 36'h000000000);
    expect_cmd(8'h31, 36'h000010040);
    expect_cmd(8'h32, 36'h000000001);
    expect_cmd(8'h33, 36'h000000006);
    check_stream("keep");

    // Reset asserted while a SLOT_CFG command is on the port.
    request(1'b1, 1'b0, 9'd3, 32'd8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_slot_cmd", {56'd0, ul_eve_cmd}, 64'h31);
    rst = 1'b1;
    #1;
    chk("mid_rst_stb",  {63'd0, ul_eve_stb}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("mid_rst_cmd",  {56'd0, ul_eve_cmd}, 64'd0);
    chk("mid_rst_ptr",  {28'd0, ul_eve_ptr}, 64'd0);
    rst = 1'b0;
    request(1'b1, 1'b0, 9'd1, 32'd6, 1'b0);
    wait_done("after_rst", 50);
    chk("after_rst_done_t", 64'(done_cyc - t0), 64'd6);
    expect_cmd(8'h30, 36'h000000000);
    expect_cmd(8'h31, 36'h000010040);
    expect_cmd(8'h32, 36'h000000001);
    expect_cmd(8'h33, 36'h000000006);
    check_stream("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
